riscv_fetch_unit: RTL

RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

---
 rtl/riscv_pkg.sv | 17 +
 rtl/riscv_fetch_fifo.sv | 78 +++++++
 rtl/riscv_fetch_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction fetch unit.
//   fetch_state_e : fetch FSM states (BOOT, FETCH, DRAIN)
//   INSTR_BYTES   : size of one instruction word in bytes (PC stride)
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// ---------------------------------------------------------------------------
// riscv_fetch_fifo
// Synchronous FIFO with flush, registered write and combinational head read.
// Parameters:
//   WIDTH  entry width in bits
//   DEPTH  number of entries (power of two, >= 2)
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset (empties the FIFO)
//   flush      empties the FIFO on the next edge; same-cycle push/pop ignored
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        remove the head (ignored when empty)
//   head_data  head entry; holds the last shown head while empty
//   count      number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module riscv_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] last_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && (count_reg != '0) && !flush;

  // Register-file storage: one write-enabled word per entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_reg == AW'(gi))) begin
        mem[gi] <= push_data;
      end
    end
  end

  // While empty, the output keeps showing the most recently visible head.
  assign head_data = (count_reg != '0) ? mem[rd_ptr_reg] : last_reg;
  assign count     = count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      last_reg   <= '0;
    end else begin
      last_reg <= head_data;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      end
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// ---------------------------------------------------------------------------
// riscv_fetch_unit
// Sequential instruction prefetcher with an in-order memory interface,
// a prefetch FIFO of {PC, instruction} and redirect/flush handling.
// Parameters:
//   XLEN      PC / address width
//   DEPTH     FIFO entries and maximum outstanding requests (2..16, pow2)
//   RESET_PC  first fetch address after reset
// Ports:
//   clk, reset                      clock; asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request channel
//   imem_resp_valid/data            in-order response, no backpressure
//   instr_valid/ready, instr,       FIFO head towards the core
//   instr_addr
//   redirect, redirect_pc           taken branch/jump: flush and refetch
//   fetch_count, flush_count        statistics
// Optional feature: define RISCV_FETCH_STATS_EN to build the statistics
// counters; otherwise fetch_count/flush_count are constant 0.
// ---------------------------------------------------------------------------
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_addr,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     fetch_count,
  output logic [31:0]     flush_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = XLEN + 32;

  fetch_state_e    state_reg;
  logic [XLEN-1:0] fetch_pc_reg;
  logic [CW-1:0]   outstanding_reg;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop_count_reg;
  logic [CW-1:0]   drop_count_next;

  // Issued-address queue, parallel to the memory pipeline.
  logic [XLEN-1:0] addr_mem [DEPTH];
  logic [AW-1:0]   aq_wr_reg;
  logic [AW-1:0]   aq_rd_reg;

  logic            active_redirect;
  logic            accept;
  logic            resp_drop;
  logic            resp_push;
  logic            pop;
  logic [CW-1:0]   fifo_count;
  logic [DW-1:0]   head_data;
  logic [XLEN-1:0] redirect_pc_aligned;

  assign redirect_pc_aligned = redirect_pc & ~XLEN'(3);
  assign active_redirect     = redirect && (state_reg != BOOT);

  // Every accepted request reserves a FIFO slot until its instruction is
  // consumed, so the FIFO can never overflow.
  assign imem_req_valid = (state_reg == FETCH) && !redirect &&
                          ((fifo_count + outstanding_reg) < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign accept         = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop_count_reg != '0);
  assign resp_push = imem_resp_valid && (drop_count_reg == '0) && !active_redirect;

  assign instr_valid = (fifo_count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr       = head_data[31:0];
  assign instr_addr  = head_data[DW-1:32];

  assign outstanding_next = outstanding_reg + CW'(accept) - CW'(imem_resp_valid);

  // On redirect, everything still in flight after this cycle becomes stale.
  always_comb begin
    drop_count_next = drop_count_reg - CW'(resp_drop);
    if (active_redirect) drop_count_next = outstanding_next;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_addr_q
    always_ff @(posedge clk) begin
      if (accept && (aq_wr_reg == AW'(gi))) begin
        addr_mem[gi] <= fetch_pc_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= BOOT;
      fetch_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      drop_count_reg  <= '0;
      aq_wr_reg       <= '0;
      aq_rd_reg       <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      drop_count_reg  <= drop_count_next;
      case (state_reg)
        BOOT: state_reg <= FETCH;
        FETCH, DRAIN: begin
          if (redirect) begin
            fetch_pc_reg <= redirect_pc_aligned;
            state_reg    <= (drop_count_next != '0) ? DRAIN : FETCH;
            aq_wr_reg    <= '0;
            aq_rd_reg    <= '0;
          end else begin
            if (accept) begin
              fetch_pc_reg <= fetch_pc_reg + XLEN'(INSTR_BYTES);
              aq_wr_reg    <= aq_wr_reg + AW'(1);
            end
            if (resp_push) aq_rd_reg <= aq_rd_reg + AW'(1);
            if ((state_reg == DRAIN) && (drop_count_next == '0)) state_reg <= FETCH;
          end
        end
        default: state_reg <= BOOT;
      endcase
    end
  end

  riscv_fetch_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (active_redirect),
    .push      (resp_push),
    .push_data ({addr_mem[aq_rd_reg], imem_resp_data}),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count)
  );

`ifdef RISCV_FETCH_STATS_EN
  logic [31:0] fetch_count_reg;
  logic [31:0] flush_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (accept)          fetch_count_reg <= fetch_count_reg + 32'd1;
      if (active_redirect) flush_count_reg <= flush_count_reg + 32'd1;
    end
  end

  assign fetch_count = fetch_count_reg;
  assign flush_count = flush_count_reg;
`else
  assign fetch_count = '0;
  assign flush_count = '0;
`endif

endmodule
